// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory line port between the I-cache and D-cache.
// The winning request is latched and held on pmem until pmem_resp, then returned to its owner.
module pmem_arbiter #(
    parameter int s_addr  = 32,
    parameter int s_line  = 256,
    parameter int RR_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [s_addr-1:0] icache_address,
    input  logic              icache_read,
    input  logic              icache_write,
    input  logic [s_line-1:0] icache_wdata,
    output logic [s_line-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic [s_addr-1:0] dcache_address,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [s_line-1:0] dcache_wdata,
    output logic [s_line-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic [s_addr-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_d;
    logic              grant_d;
    logic [s_line-1:0] rdata_q;
    logic              i_act;
    logic              d_act;
    logic              pick_d;
    logic              start;
    logic              sel_write;
    logic              sel_read;

    assign i_act = icache_read | icache_write;
    assign d_act = dcache_read | dcache_write;

    // Ties alternate in round-robin mode; otherwise the D-cache always wins.
    always_comb begin
        pick_d = d_act;
        if (i_act && d_act) begin
            pick_d = (RR_MODE != 0) ? ~last_d : 1'b1;
        end
    end

    // read&write together is served as a write
    assign sel_write = pick_d ? dcache_write : icache_write;
    assign sel_read  = pick_d ? (dcache_read & ~dcache_write)
                              : (icache_read & ~icache_write);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        icache_resp = 1'b0;
        dcache_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_act || d_act) begin
                    state_nxt = BUSY;
                    start     = 1'b1;
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                icache_resp = ~grant_d;
                dcache_resp = grant_d;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d       <= 1'b1;
            grant_d      <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            rdata_q      <= '0;
        end else if (start) begin
            grant_d      <= pick_d;
            last_d       <= pick_d;
            pmem_address <= pick_d ? dcache_address : icache_address;
            pmem_wdata   <= pick_d ? dcache_wdata : icache_wdata;
            pmem_read    <= sel_read;
            pmem_write   <= sel_write;
        end else if (state == BUSY && pmem_resp) begin
            rdata_q    <= pmem_rdata;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end
    end

    assign icache_rdata = rdata_q;
    assign dcache_rdata = rdata_q;

endmodule
